// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory request/acknowledge bus
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetcher with redirect and IR hand-off
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch_valid,
  input  logic [15:0]               branch_target,
  instr_fetch_unit_if.master        imem,
  output logic [15:0]               ir,
  output logic [15:0]               ir_pc,
  output logic                      ir_valid,
  input  logic                      ir_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        issue;
  logic        capture;

  // A new fetch may only start once the IR slot is free or being consumed this cycle.
  always_comb begin
    issue   = (state == IDLE) && !stall && !branch_valid && (!ir_valid || ir_ready);
    capture = (state == REQ) && imem.imem_ack && !branch_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      ir             <= 16'h0000;
      ir_pc          <= 16'h0000;
      ir_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_valid) begin
            pc <= branch_target;
          end else if (issue) begin
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc;
            pc             <= pc + 16'd1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (branch_valid) begin
            pc <= branch_target;
          end
          // A redirect without ack keeps the bus request alive; its data is dropped later.
          if (imem.imem_ack) begin
            imem.imem_req <= 1'b0;
            state         <= IDLE;
          end else if (branch_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (branch_valid) begin
            pc <= branch_target;
          end
          if (imem.imem_ack) begin
            imem.imem_req <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          imem.imem_req <= 1'b0;
        end
      endcase

      if (capture) begin
        ir    <= imem.imem_rdata;
        ir_pc <= imem.imem_addr;
      end

      if (branch_valid) begin
        ir_valid <= 1'b0;
      end else if (capture) begin
        ir_valid <= 1'b1;
      end else if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        bv = 1'b0;
  logic [15:0] bt = 16'h0000;
  logic        ready = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] rdata = 16'h0000;
  logic [15:0] ir, ir_pc;
  logic        ir_valid;

  logic        rst2_n = 1'b0;
  logic [15:0] ir2, ir2_pc;
  logic        ir2_valid;
  logic        prev2 = 1'b0;
  logic [15:0] q2[$];

  int total = 0;
  int passed = 0;

  // Reference model: one outstanding word, flagged for discard after a redirect.
  logic        m_busy = 1'b0, m_disc = 1'b0, m_irv = 1'b0;
  logic [15:0] m_pc = 16'h0, m_addr = 16'h0, m_ir = 16'h0, m_irpc = 16'h0;

  logic [15:0] seen_pc[4];
  logic [15:0] seen_ir[4];
  int          nseen;

  instr_fetch_unit_if imem_bus ();
  instr_fetch_unit_if imem2 ();

  assign imem_bus.imem_ack   = ack;
  assign imem_bus.imem_rdata = rdata;
  assign imem2.imem_ack      = imem2.imem_req;
  assign imem2.imem_rdata    = imem2.imem_addr ^ 16'hA5A5;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_valid(bv), .branch_target(bt),
    .imem(imem_bus), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ready)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(1'b0), .branch_valid(1'b0), .branch_target(16'h0000),
    .imem(imem2), .ir(ir2), .ir_pc(ir2_pc), .ir_valid(ir2_valid), .ir_ready(1'b1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst2_n && imem2.imem_req && !prev2 && q2.size() < 4) q2.push_back(imem2.imem_addr);
    prev2 = rst2_n && imem2.imem_req;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic issue, cap;
    if (!rst_n) begin
      m_busy = 0; m_disc = 0; m_pc = 16'h0; m_addr = 16'h0;
      m_ir = 16'h0; m_irpc = 16'h0; m_irv = 0;
    end else begin
      issue = !m_busy && !stall && !bv && (!m_irv || ready);
      cap   = m_busy && !m_disc && ack && !bv;
      if (cap) begin
        m_ir   = m_addr ^ 16'hA5A5;
        m_irpc = m_addr;
      end
      if (bv) m_irv = 0;
      else if (cap) m_irv = 1;
      else if (ready) m_irv = 0;
      if (issue) begin
        m_addr = m_pc; m_pc = m_pc + 16'd1; m_busy = 1; m_disc = 0;
      end else if (m_busy && ack) begin
        m_busy = 0; m_disc = 0;
      end else if (m_busy && bv) begin
        m_disc = 1;
      end
      if (bv) m_pc = bt;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic rd, input logic a);
    @(negedge clk);
    rst_n = r; stall = s; bv = b; bt = t; ready = rd; ack = a;
    rdata = imem_bus.imem_addr ^ 16'hA5A5;
    model_step();
    @(posedge clk);
    #1;
    chk("imem_req",  {15'b0, imem_bus.imem_req}, {15'b0, m_busy});
    chk("imem_addr", imem_bus.imem_addr, m_addr);
    chk("ir",        ir, m_ir);
    chk("ir_pc",     ir_pc, m_irpc);
    chk("ir_valid",  {15'b0, ir_valid}, {15'b0, m_irv});
  endtask

  initial begin
    // Reset must override a simultaneous branch and ack.
    step(0, 0, 1, 16'h1234, 1, 1);
    step(0, 0, 1, 16'h1234, 1, 1);
    chk("rst_ir_valid", {15'b0, ir_valid}, 16'h0);
    chk("rst_addr", imem_bus.imem_addr, 16'h0000);
    rst2_n = 1'b1;

    // Streaming fetch, memory acks one cycle after each request.
    nseen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 16'h0, 1, m_busy);
      if (ir_valid && nseen < 4) begin
        seen_pc[nseen] = ir_pc;
        seen_ir[nseen] = ir;
        nseen++;
      end
    end
    chk("stream_count", 16'(nseen), 16'd4);
    for (int k = 0; k < 4; k++) begin
      chk("stream_ir_pc", seen_pc[k], 16'(k));
      chk("stream_ir", seen_ir[k], 16'(k) ^ 16'hA5A5);
    end

    // Decode back-pressure holds IR and blocks issue.
    step(0, 0, 0, 16'h0, 1, 0);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 16'h0, 0, 0);
      chk("hold_ir", ir, 16'hA5A5);
      chk("hold_noreq", {15'b0, imem_bus.imem_req}, 16'h0);
    end
    step(1, 0, 0, 16'h0, 1, 0);
    chk("release_req", {15'b0, imem_bus.imem_req}, 16'h1);
    chk("release_addr", imem_bus.imem_addr, 16'h0001);

    // Redirect while addr 2 is outstanding; late ack data is dropped.
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 1, 0);
    chk("issue_addr2", imem_bus.imem_addr, 16'h0002);
    step(1, 0, 1, 16'h0040, 1, 0);
    chk("drain_req_kept", {15'b0, imem_bus.imem_req}, 16'h1);
    step(1, 0, 0, 16'h0, 1, 0);
    step(1, 0, 0, 16'h0, 1, 0);
    step(1, 0, 0, 16'h0, 1, 1);
    chk("drain_discard_valid", {15'b0, ir_valid}, 16'h0);
    chk("drain_ir_pc_kept", ir_pc, 16'h0001);
    step(1, 0, 0, 16'h0, 1, 0);
    chk("after_drain_addr", imem_bus.imem_addr, 16'h0040);

    // Branch in the same cycle as the ack for addr 5.
    step(0, 0, 0, 16'h0, 1, 0);
    for (int k = 0; k < 40 && !(m_busy && m_addr == 16'd5); k++) step(1, 0, 0, 16'h0, 1, m_busy);
    chk("reach_addr5", imem_bus.imem_addr, 16'h0005);
    step(1, 0, 1, 16'h0010, 1, 1);
    chk("brack_valid", {15'b0, ir_valid}, 16'h0);
    chk("brack_ir_pc", ir_pc, 16'h0004);
    step(1, 0, 0, 16'h0, 1, 0);
    chk("brack_next_addr", imem_bus.imem_addr, 16'h0010);

    // Reset during an outstanding request with a branch pending; late ack ignored.
    step(0, 0, 1, 16'h1234, 1, 0);
    chk("midrst_req", {15'b0, imem_bus.imem_req}, 16'h0);
    chk("midrst_ir", ir, 16'h0000);
    step(1, 1, 0, 16'h0, 1, 1);
    chk("late_ack_valid", {15'b0, ir_valid}, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0);
    chk("first_issue_addr", imem_bus.imem_addr, 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           16'($urandom),
           ($urandom_range(0, 1) == 1),
           m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0));
    end

    // Fetch addresses from RESET_PC=16'hFFFE wrap through zero.
    chk("wrap_count", 16'(q2.size()), 16'd4);
    if (q2.size() >= 3) begin
      chk("wrap_0", q2[0], 16'hFFFE);
      chk("wrap_1", q2[1], 16'hFFFF);
      chk("wrap_2", q2[2], 16'h0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
